// File: rtl/memory_bus.sv
// memory_bus: bridges the 8008 core memory interface to ROM, RAM and board
// peripherals. Decodes the 14-bit address, sequences each access through a
// small FSM and returns read data with a 4-phase completion handshake.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   address, data_in    CPU byte address / write data
//   write_enable        1=write, 0=read, sampled with bus_enable
//   bus_enable          CPU request, held until bus_done is seen
//   data_out, bus_done  read data / access complete
//   rom_address/data    ROM block (registered read data)
//   ram_*               RAM block (combinational read, write strobe)
//   leds, ioport        output registers
//   buttons             raw asynchronous board buttons
module memory_bus #(
    parameter int unsigned RAM_SIZE_BITS = 9,
    parameter int unsigned ROM_SIZE_BITS = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [13:0]              address,
    input  logic [7:0]               data_in,
    output logic [7:0]               data_out,
    input  logic                     bus_enable,
    input  logic                     write_enable,
    output logic                     bus_done,
    output logic [ROM_SIZE_BITS-1:0] rom_address,
    input  logic [7:0]               rom_data,
    output logic [RAM_SIZE_BITS-1:0] ram_address,
    output logic [7:0]               ram_data_in,
    input  logic [7:0]               ram_data_out,
    output logic                     ram_write_enable,
    output logic [7:0]               leds,
    input  logic [3:0]               buttons,
    output logic [7:0]               ioport
);

    typedef enum logic [1:0] {IDLE, ROM_WAIT, EXEC, DONE} state_t;

    localparam logic [1:0] SEL_ROM    = 2'b00;
    localparam logic [1:0] SEL_RAM    = 2'b01;
    localparam logic [1:0] SEL_PERIPH = 2'b10;

    localparam logic [1:0] PER_LEDS    = 2'd0;
    localparam logic [1:0] PER_BUTTONS = 2'd1;
    localparam logic [1:0] PER_IOPORT  = 2'd2;

    state_t      state_q, state_d;
    logic [13:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        bus_done_q, bus_done_d;
    logic        ram_we_q, ram_we_d;
    logic [7:0]  leds_q, leds_d;
    logic [7:0]  ioport_q, ioport_d;
    logic [3:0]  btn_meta_q, btn_meta_d;
    logic [3:0]  btn_sync_q, btn_sync_d;
    logic [7:0]  read_data_c;

    // Targets are driven from the request latched in IDLE; RAM upper bit is tied low.
    assign rom_address      = ROM_SIZE_BITS'(addr_q[11:0]);
    assign ram_address      = RAM_SIZE_BITS'(addr_q[7:0]);
    assign ram_data_in      = wdata_q;
    assign ram_write_enable = ram_we_q;
    assign data_out         = data_out_q;
    assign bus_done         = bus_done_q;
    assign leds             = leds_q;
    assign ioport           = ioport_q;

    // Read-data mux over the latched address.
    always_comb begin
        read_data_c = 8'hFF;
        case (addr_q[13:12])
            SEL_ROM: read_data_c = rom_data;
            SEL_RAM: read_data_c = ram_data_out;
            SEL_PERIPH: begin
                case (addr_q[1:0])
                    PER_LEDS:    read_data_c = leds_q;
                    PER_BUTTONS: read_data_c = {4'b0000, btn_sync_q};
                    PER_IOPORT:  read_data_c = ioport_q;
                    default:     read_data_c = 8'hFF;
                endcase
            end
            default: read_data_c = 8'hFF;
        endcase
    end

    // Next-state and datapath.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        bus_done_d = 1'b0;
        ram_we_d   = 1'b0;
        leds_d     = leds_q;
        ioport_d   = ioport_q;
        btn_meta_d = buttons;
        btn_sync_d = btn_meta_q;

        case (state_q)
            IDLE: begin
                if (bus_enable) begin
                    addr_d  = address;
                    we_d    = write_enable;
                    wdata_d = data_in;
                    // Strobe is registered here so it is high for exactly the EXEC cycle.
                    ram_we_d = write_enable && (address[13:12] == SEL_RAM);
                    if (!write_enable && (address[13:12] == SEL_ROM)) begin
                        state_d = ROM_WAIT;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            ROM_WAIT: begin
                state_d = EXEC;
            end
            EXEC: begin
                state_d    = DONE;
                bus_done_d = 1'b1;
                if (we_q) begin
                    if (addr_q[13:12] == SEL_PERIPH) begin
                        if (addr_q[1:0] == PER_LEDS) begin
                            leds_d = wdata_q;
                        end
                        if (addr_q[1:0] == PER_IOPORT) begin
                            ioport_d = wdata_q;
                        end
                    end
                end else begin
                    data_out_d = read_data_c;
                end
            end
            DONE: begin
                if (bus_enable) begin
                    bus_done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= 14'd0;
            we_q       <= 1'b0;
            wdata_q    <= 8'h00;
            data_out_q <= 8'h00;
            bus_done_q <= 1'b0;
            ram_we_q   <= 1'b0;
            leds_q     <= 8'h00;
            ioport_q   <= 8'h00;
            btn_meta_q <= 4'h0;
            btn_sync_q <= 4'h0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            bus_done_q <= bus_done_d;
            ram_we_q   <= ram_we_d;
            leds_q     <= leds_d;
            ioport_q   <= ioport_d;
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
        end
    end

endmodule

// File: tb/tb_memory_bus.sv
// Testbench for memory_bus: ROM/RAM block models plus a reference model of
// the memory map (arrays and registers updated by the address-decode rules).
module tb_memory_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] address;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        bus_enable;
    logic        write_enable;
    logic        bus_done;
    logic [11:0] rom_address;
    logic [7:0]  rom_data;
    logic [8:0]  ram_address;
    logic [7:0]  ram_data_in;
    logic [7:0]  ram_data_out;
    logic        ram_write_enable;
    logic [7:0]  leds;
    logic [3:0]  buttons;
    logic [7:0]  ioport;

    memory_bus #(.RAM_SIZE_BITS(9), .ROM_SIZE_BITS(12)) dut (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in),
        .data_out(data_out), .bus_enable(bus_enable), .write_enable(write_enable),
        .bus_done(bus_done), .rom_address(rom_address), .rom_data(rom_data),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out), .ram_write_enable(ram_write_enable),
        .leds(leds), .buttons(buttons), .ioport(ioport)
    );

    always #5 clk = ~clk;

    // ROM block (registered) and RAM block (combinational read).
    logic [7:0] rom_mem [4096];
    logic [7:0] ram_mem [512];
    always @(posedge clk) rom_data <= rom_mem[rom_address];
    assign ram_data_out = ram_mem[ram_address];

    int          we_pulses;
    logic [8:0]  we_addr;
    always @(posedge clk) begin
        if (ram_write_enable) begin
            ram_mem[ram_address] <= ram_data_in;
            we_pulses = we_pulses + 1;
            we_addr   = ram_address;
        end
    end

    // Reference model of the memory map.
    logic [7:0] ref_ram [256];
    logic [7:0] ref_leds, ref_ioport, ref_last;
    logic [3:0] ref_btn;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [7:0] ref_read(input logic [13:0] a);
        case (a[13:12])
            2'd0: return rom_mem[a[11:0]];
            2'd1: return ref_ram[a[7:0]];
            2'd2: begin
                case (a[1:0])
                    2'd0:    return ref_leds;
                    2'd1:    return {4'b0000, ref_btn};
                    2'd2:    return ref_ioport;
                    default: return 8'hFF;
                endcase
            end
            default: return 8'hFF;
        endcase
    endfunction

    function automatic void ref_write(input logic [13:0] a, input logic [7:0] d);
        if (a[13:12] == 2'd1) ref_ram[a[7:0]] = d;
        if (a[13:12] == 2'd2 && a[1:0] == 2'd0) ref_leds = d;
        if (a[13:12] == 2'd2 && a[1:0] == 2'd2) ref_ioport = d;
    endfunction

    // Latency counts edges from the one sampling bus_enable (that edge is 1).
    function automatic int ref_latency(input logic [13:0] a, input logic w);
        return (a[13:12] == 2'd0 && !w) ? 3 : 2;
    endfunction

    // One 4-phase access; returns observations only.
    task automatic bus_access(input logic [13:0] a, input logic w, input logic [7:0] d,
                              output logic [7:0] rd, output int lat, output int pulses,
                              output logic [8:0] wa);
        @(negedge clk);
        address = a; write_enable = w; data_in = d; bus_enable = 1'b1;
        we_pulses = 0; we_addr = 9'h1FF;
        @(posedge clk); #1;
        lat = 1;
        while (!bus_done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = data_out; pulses = we_pulses; wa = we_addr;
        @(negedge clk); bus_enable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [7:0] rd; int lat, p; logic [8:0] wa;
        n_checks++; if ({bus_done, data_out, ram_write_enable, leds, ioport} !== 25'd0)
            $display("FAIL por_outputs got %h want 0", {bus_done, data_out, ram_write_enable, leds, ioport}); else n_pass++;
        @(negedge clk); reset = 1'b0;
        bus_access(14'h2000, 1'b1, 8'h66, rd, lat, p, wa);
        bus_access(14'h2002, 1'b1, 8'h77, rd, lat, p, wa);
        @(posedge clk); #3; reset = 1'b1; #1;
        n_checks++; if (leds !== 8'h00 || ioport !== 8'h00 || bus_done !== 1'b0 || data_out !== 8'h00)
            $display("FAIL async_reset leds=%h ioport=%h done=%b dout=%h want 0", leds, ioport, bus_done, data_out); else n_pass++;
        @(negedge clk); reset = 1'b0;
        ref_leds = 8'h00; ref_ioport = 8'h00; ref_last = 8'h00;
        bus_access(14'h2000, 1'b0, 8'h00, rd, lat, p, wa);
        n_checks++; if (rd !== 8'h00) $display("FAIL reset_read got %h want 00", rd); else n_pass++;
        n_checks++; if (lat !== 2) $display("FAIL reset_read_latency got %0d want 2", lat); else n_pass++;
    endtask

    task automatic test_ram();
        logic [7:0] rd; int lat, p; logic [8:0] wa;
        bus_access(14'h1034, 1'b1, 8'h5A, rd, lat, p, wa); ref_write(14'h1034, 8'h5A);
        n_checks++; if (p !== 1 || wa !== 9'h034) $display("FAIL ram_strobe pulses=%0d addr=%h want 1/034", p, wa); else n_pass++;
        n_checks++; if (lat !== 2) $display("FAIL ram_write_latency got %0d want 2", lat); else n_pass++;
        bus_access(14'h1034, 1'b0, 8'h00, rd, lat, p, wa);
        n_checks++; if (rd !== 8'h5A || p !== 0) $display("FAIL ram_read got %h pulses=%0d want 5A/0", rd, p); else n_pass++;
        bus_access(14'h1134, 1'b0, 8'h00, rd, lat, p, wa);
        n_checks++; if (rd !== 8'h5A) $display("FAIL ram_alias got %h want 5A", rd); else n_pass++;
        ref_last = 8'h5A;
    endtask

    task automatic test_rom();
        logic [7:0] rd; int lat, p; logic [8:0] wa;
        bus_access(14'h0123, 1'b0, 8'h00, rd, lat, p, wa);
        n_checks++; if (rd !== 8'hC3) $display("FAIL rom_read got %h want C3", rd); else n_pass++;
        n_checks++; if (lat !== 3) $display("FAIL rom_latency got %0d want 3", lat); else n_pass++;
        bus_access(14'h0123, 1'b1, 8'h00, rd, lat, p, wa);
        n_checks++; if (p !== 0 || lat !== 2) $display("FAIL rom_write pulses=%0d lat=%0d want 0/2", p, lat); else n_pass++;
        n_checks++; if (data_out !== 8'hC3) $display("FAIL rom_write_dout_hold got %h want C3", data_out); else n_pass++;
        bus_access(14'h0123, 1'b0, 8'h00, rd, lat, p, wa);
        n_checks++; if (rd !== 8'hC3) $display("FAIL rom_readback got %h want C3", rd); else n_pass++;
        ref_last = 8'hC3;
    endtask

    task automatic test_periph();
        logic [7:0] rd; int lat, p; logic [8:0] wa;
        bus_access(14'h2000, 1'b1, 8'hA5, rd, lat, p, wa); ref_write(14'h2000, 8'hA5);
        n_checks++; if (leds !== 8'hA5) $display("FAIL leds_write got %h want A5", leds); else n_pass++;
        bus_access(14'h2002, 1'b1, 8'h3C, rd, lat, p, wa); ref_write(14'h2002, 8'h3C);
        n_checks++; if (ioport !== 8'h3C) $display("FAIL ioport_write got %h want 3C", ioport); else n_pass++;
        bus_access(14'h2000, 1'b0, 8'h00, rd, lat, p, wa);
        n_checks++; if (rd !== 8'hA5) $display("FAIL leds_read got %h want A5", rd); else n_pass++;
        bus_access(14'h2002, 1'b0, 8'h00, rd, lat, p, wa);
        n_checks++; if (rd !== 8'h3C) $display("FAIL ioport_read got %h want 3C", rd); else n_pass++;
        @(negedge clk); buttons = 4'b1010; ref_btn = 4'b1010;
        repeat (3) @(posedge clk);
        bus_access(14'h2001, 1'b0, 8'h00, rd, lat, p, wa);
        n_checks++; if (rd !== 8'h0A) $display("FAIL buttons_read got %h want 0A", rd); else n_pass++;
        ref_last = 8'h0A;
    endtask

    task automatic test_unmapped();
        logic [7:0] rd; int lat, p; logic [8:0] wa;
        bus_access(14'h3FFF, 1'b0, 8'h00, rd, lat, p, wa);
        n_checks++; if (rd !== 8'hFF || lat !== 2) $display("FAIL unmapped_read got %h lat=%0d want FF/2", rd, lat); else n_pass++;
        ref_last = 8'hFF;
        bus_access(14'h3000, 1'b1, 8'h12, rd, lat, p, wa);
        n_checks++; if (p !== 0 || leds !== ref_leds || ioport !== ref_ioport)
            $display("FAIL unmapped_write_3000 pulses=%0d leds=%h ioport=%h want 0/%h/%h", p, leds, ioport, ref_leds, ref_ioport); else n_pass++;
        bus_access(14'h2003, 1'b1, 8'h12, rd, lat, p, wa);
        n_checks++; if (p !== 0 || leds !== ref_leds || ioport !== ref_ioport)
            $display("FAIL unmapped_write_2003 pulses=%0d leds=%h ioport=%h want 0/%h/%h", p, leds, ioport, ref_leds, ref_ioport); else n_pass++;
        bus_access(14'h2003, 1'b0, 8'h00, rd, lat, p, wa);
        n_checks++; if (rd !== 8'hFF) $display("FAIL unmapped_periph_read got %h want FF", rd); else n_pass++;
    endtask

    task automatic test_handshake();
        int lat;
        @(negedge clk);
        address = 14'h1060; write_enable = 1'b1; data_in = 8'h77; bus_enable = 1'b1;
        we_pulses = 0;
        lat = 0;
        @(posedge clk); #1;
        while (!bus_done && lat < 10) begin @(posedge clk); #1; lat++; end
        n_checks++; if (!bus_done) $display("FAIL handshake_timeout done=%b want 1", bus_done); else n_pass++;
        ref_write(14'h1060, 8'h77);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++; if (bus_done !== 1'b1 || we_pulses !== 1 || data_out !== ref_last)
                $display("FAIL handshake_hold_%0d done=%b pulses=%0d dout=%h want 1/1/%h", i, bus_done, we_pulses, data_out, ref_last); else n_pass++;
        end
        @(negedge clk); bus_enable = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus_done !== 1'b0) $display("FAIL handshake_release done=%b want 0", bus_done); else n_pass++;
    endtask

    task automatic test_abort();
        logic [7:0] rd; int lat, p; logic [8:0] wa;
        @(negedge clk);
        address = 14'h1050; write_enable = 1'b1; data_in = ~ref_ram[8'h50]; bus_enable = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (ram_write_enable !== 1'b1) $display("FAIL abort_exec_strobe got %b want 1", ram_write_enable); else n_pass++;
        #2; reset = 1'b1; bus_enable = 1'b0; #1;
        n_checks++; if (ram_write_enable !== 1'b0 || bus_done !== 1'b0)
            $display("FAIL abort_outputs we=%b done=%b want 0/0", ram_write_enable, bus_done); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk); reset = 1'b0;
        ref_leds = 8'h00; ref_ioport = 8'h00; ref_last = 8'h00;
        repeat (3) begin
            @(posedge clk); #1;
            n_checks++; if (bus_done !== 1'b0) $display("FAIL abort_no_done got %b want 0", bus_done); else n_pass++;
        end
        n_checks++; if (ram_mem[9'h050] !== ref_ram[8'h50]) $display("FAIL abort_ram got %h want %h", ram_mem[9'h050], ref_ram[8'h50]); else n_pass++;
        bus_access(14'h1050, 1'b0, 8'h00, rd, lat, p, wa);
        n_checks++; if (rd !== ref_ram[8'h50]) $display("FAIL abort_readback got %h want %h", rd, ref_ram[8'h50]); else n_pass++;
        ref_last = rd;
    endtask

    task automatic test_random();
        logic [7:0] rd, exp; int lat, p; logic [8:0] wa;
        logic [13:0] a; logic w; logic [7:0] d;
        @(negedge clk); buttons = 4'($urandom); ref_btn = buttons;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            a = 14'($urandom); w = 1'($urandom); d = 8'($urandom);
            exp = ref_read(a);
            bus_access(a, w, d, rd, lat, p, wa);
            n_checks++; if (lat !== ref_latency(a, w)) $display("FAIL rand_latency_%0d a=%h got %0d want %0d", i, a, lat, ref_latency(a, w)); else n_pass++;
            if (w) begin
                ref_write(a, d);
                n_checks++; if (rd !== ref_last) $display("FAIL rand_dout_hold_%0d got %h want %h", i, rd, ref_last); else n_pass++;
            end else begin
                ref_last = exp;
                n_checks++; if (rd !== exp) $display("FAIL rand_read_%0d a=%h got %h want %h", i, a, rd, exp); else n_pass++;
            end
            n_checks++; if (p !== ((w && a[13:12] == 2'd1) ? 1 : 0) || (p == 1 && wa !== {1'b0, a[7:0]}))
                $display("FAIL rand_strobe_%0d a=%h pulses=%0d addr=%h", i, a, p, wa); else n_pass++;
            n_checks++; if (leds !== ref_leds || ioport !== ref_ioport)
                $display("FAIL rand_regs_%0d leds=%h ioport=%h want %h/%h", i, leds, ioport, ref_leds, ref_ioport); else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1; address = '0; data_in = '0; bus_enable = 1'b0;
        write_enable = 1'b0; buttons = 4'h0;
        we_pulses = 0; we_addr = '0;
        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'($urandom);
        rom_mem[12'h123] = 8'hC3;
        for (int i = 0; i < 512; i++) ram_mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) ref_ram[i] = ram_mem[i];
        ref_leds = 8'h00; ref_ioport = 8'h00; ref_last = 8'h00; ref_btn = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_ram();
        test_rom();
        test_periph();
        test_unmapped();
        test_handshake();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/memory_bus.md
Name: memory_bus

Overview:
- Sits between the 8008 core's memory interface and the on-chip storage: the ROM block, the 256-byte RAM block, and the board peripherals (LEDs, buttons, I/O port).
- Decodes the 14-bit CPU address and sequences each access through a small state machine.
- Returns read data and a completion handshake, so the core is independent of per-target latency.

Parameters:
- RAM_SIZE_BITS, 9, width of the RAM address bus driven to the RAM block.
- ROM_SIZE_BITS, 12, width of the ROM address bus (4096 bytes).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  14  CPU byte address.
- data_in  input  8  CPU write data.
- data_out  output  8  read data returned to CPU; valid while bus_done=1.
- bus_enable  input  1  CPU request; held high until bus_done is seen.
- write_enable  input  1  1=write, 0=read; sampled with bus_enable.
- bus_done  output  1  access complete.
- rom_address  output  ROM_SIZE_BITS  to ROM block.
- rom_data  input  8  ROM data, registered, valid one cycle after rom_address.
- ram_address  output  RAM_SIZE_BITS  to RAM block.
- ram_data_in  output  8  RAM write data.
- ram_data_out  input  8  RAM combinational read data.
- ram_write_enable  output  1  RAM write strobe.
- leds  output  8  LED register.
- buttons  input  4  raw board buttons (asynchronous).
- ioport  output  8  general output port register.

Behaviour:
- Clock and reset: single clock domain, clk. reset is asynchronous and active-high.
- Values while reset is high:
  - state=IDLE.
  - bus_done=0, data_out=0x00, ram_write_enable=0.
  - leds=0x00, ioport=0x00, button sync flops=0.
  - latched address and data = 0.
- Reset mid-access aborts the access: no write is committed after reset rises, and no bus_done is issued for the aborted request.
- Address decode uses address[13:12]:
  - 00: ROM. rom_address = address[11:0].
  - 01: RAM. ram_address = {1'b0, address[7:0]}; upper RAM address bit is always 0, giving 256 bytes and aliasing every 256 bytes across 0x1000-0x1FFF.
  - 10: peripherals, decoded on address[1:0]:
    - 0 = leds (R/W).
    - 1 = buttons (R only; value {4'b0, sync buttons}).
    - 2 = ioport (R/W).
    - 3 = unmapped.
    - Peripherals alias across 0x2000-0x2FFF.
  - 11: unmapped. Reads return 0xFF; writes are dropped.
- Address, write_enable and data_in are latched when a request is accepted in IDLE. rom_address, ram_address and ram_data_in are driven from the latched values.
- buttons pass through a 2-flop synchronizer. A button read returns the second-flop value.
- State machine:
  - IDLE: waits for bus_enable=1.
    - Write to RAM: ram_write_enable=1 for exactly the following cycle.
    - Write to leds/ioport: register updates on the following edge.
    - Write to ROM, buttons or unmapped: ignored.
    - All writes go to EXEC.
    - Read of ROM goes to ROM_WAIT. All other reads go to EXEC.
  - ROM_WAIT: one cycle; the ROM registers its output.
  - EXEC: for a read, captures data_out from the selected source (rom_data, ram_data_out, peripheral register, or 0xFF). For a write, the write is performed this cycle. Next state is DONE.
  - DONE: bus_done=1 and data_out holds. Remains in DONE while bus_enable=1. Returns to IDLE when bus_enable=0, with bus_done=0 in that IDLE cycle.
- Latency, counted from the edge that samples bus_enable=1 in IDLE:
  - RAM, peripheral or unmapped access: bus_done high 2 edges later.
  - ROM read: bus_done high 3 edges later.
- Back-to-back: a new request is accepted only in IDLE. bus_enable must drop for at least 1 cycle between accesses (4-phase handshake).
- ram_write_enable is never asserted for reads, non-RAM addresses, or outside EXEC.
- data_out keeps its last read value after writes and in IDLE.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> all outputs 0 immediately. Release, then read 0x2000 -> data_out=0x00, bus_done 2 cycles after request.
- RAM write/read: write 0x5A to 0x1034, then read 0x1034 -> ram_write_enable high exactly 1 cycle with ram_address=0x034. Read returns 0x5A. Read of 0x1134 (alias) also returns 0x5A.
- ROM read: ROM model holds 0xC3 at 0x0123. Read 0x0123 -> bus_done on 3rd edge, data_out=0xC3. Write 0x00 to 0x0123 -> completes, no RAM strobe, ROM readback still 0xC3.
- Peripherals:
  - Write 0xA5 to 0x2000 -> leds=0xA5.
  - Write 0x3C to 0x2002 -> ioport=0x3C; readback of each matches.
  - buttons=4'b1010 held 3 cycles, read 0x2001 -> 0x0A.
- Unmapped: read 0x3FFF -> 0xFF. Write 0x12 to 0x3000 and 0x2003 -> no register or RAM change.
- Handshake and abort: hold bus_enable high 5 cycles after bus_done -> bus_done stays high, no second access. Assert reset in EXEC of a RAM write -> RAM contents unchanged, bus_done=0.
